// File: rtl/wash_phase_timer_if.sv
// Controller <-> phase timer bundle: phase request, power/cancel, duration
// configuration port and timer status.
interface wash_phase_timer_if #(
   parameter int CNT_W = 16
);
   logic             timer_enable;
   logic [1:0]       phase_sel;
   logic             power_on;
   logic             cancel;
   logic             cfg_we;
   logic [1:0]       cfg_addr;
   logic [CNT_W-1:0] cfg_data;
   logic             timer_done;
   logic [CNT_W-1:0] remaining;
   logic             running;
   logic             paused;

   // Controller side.
   modport master (
      output timer_enable, phase_sel, power_on, cancel,
      output cfg_we, cfg_addr, cfg_data,
      input  timer_done, remaining, running, paused
   );

   // Timer side.
   modport slave (
      input  timer_enable, phase_sel, power_on, cancel,
      input  cfg_we, cfg_addr, cfg_data,
      output timer_done, remaining, running, paused
   );
endinterface

// File: rtl/wash_phase_timer.sv
// Phase-duration timer: loads the configured duration of the requested wash
// phase and counts it down on a prescaled time base, freezing on power loss.
module wash_phase_timer #(
   parameter int CNT_W     = 16,
   parameter int PRESCALE  = 1000,
   parameter int SOAK_DEF  = 10,
   parameter int WASH_DEF  = 20,
   parameter int RINSE_DEF = 15,
   parameter int SPIN_DEF  = 8
) (
   input logic               clk,
   input logic               rst_n,
   wash_phase_timer_if.slave bus
);

   localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      COUNT,
      PAUSE,
      DONE,
      WAIT
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] dur_q [4];
   logic [1:0]       cur_phase_q;
   logic [CNT_W-1:0] remaining_q;
   logic [PRE_W-1:0] pre_q;

   logic do_load;
   logic do_clear;
   logic do_step;
   logic tick;
   logic last_tick;
   logic stop_req;

   assign tick      = (pre_q == PRE_LAST);
   assign last_tick = tick && (remaining_q == CNT_W'(1));
   assign stop_req  = bus.cancel || !bus.timer_enable;

   // NOTE: every sequential block uses non-blocking assignments so all
   // registers update from the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // NOTE: each output of this block gets a default first, so no path
   // through the case leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      do_load  = 1'b0;
      do_clear = 1'b0;
      do_step  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.timer_enable && bus.power_on && !bus.cancel) state_d = LOAD;
         end
         LOAD: begin
            do_load = 1'b1;
            state_d = (dur_q[bus.phase_sel] == '0) ? DONE : COUNT;
         end
         COUNT: begin
            if (stop_req) begin
               do_clear = 1'b1;
               state_d  = IDLE;
            end else if (bus.phase_sel != cur_phase_q) begin
               state_d = LOAD;
            end else if (!bus.power_on) begin
               state_d = PAUSE;
            end else begin
               do_step = 1'b1;
               if (last_tick) state_d = DONE;
            end
         end
         PAUSE: begin
            // The resume cycle itself counts, so each powered-down cycle
            // costs exactly one cycle of completion time.
            if (stop_req) begin
               do_clear = 1'b1;
               state_d  = IDLE;
            end else if (bus.power_on) begin
               do_step = 1'b1;
               state_d = last_tick ? DONE : COUNT;
            end
         end
         DONE: begin
            // Hold done until a powered cycle so a frozen controller sees it.
            if (bus.cancel) begin
               do_clear = 1'b1;
               state_d  = IDLE;
            end else if (bus.power_on) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (stop_req)                           state_d = IDLE;
            else if (bus.phase_sel != cur_phase_q)  state_d = LOAD;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the duration file is deliberately reset; reset must restore the
   // default phase durations and drop any runtime configuration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dur_q[0] <= CNT_W'(SOAK_DEF);
         dur_q[1] <= CNT_W'(WASH_DEF);
         dur_q[2] <= CNT_W'(RINSE_DEF);
         dur_q[3] <= CNT_W'(SPIN_DEF);
      end else if (bus.cfg_we) begin
         dur_q[bus.cfg_addr] <= bus.cfg_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_phase_q <= 2'b00;
         remaining_q <= '0;
         pre_q       <= '0;
      end else if (do_load) begin
         cur_phase_q <= bus.phase_sel;
         remaining_q <= dur_q[bus.phase_sel];
         pre_q       <= '0;
      end else if (do_clear) begin
         remaining_q <= '0;
         pre_q       <= '0;
      end else if (do_step) begin
         if (tick) begin
            pre_q <= '0;
            if (remaining_q != '0) remaining_q <= remaining_q - CNT_W'(1);
         end else begin
            pre_q <= pre_q + PRE_W'(1);
         end
      end
   end

   assign bus.remaining  = remaining_q;
   assign bus.timer_done = (state_q == DONE);
   assign bus.running    = (state_q == COUNT) || (state_q == PAUSE);
   assign bus.paused     = (state_q == PAUSE);

endmodule

// File: doc/wash_phase_timer.md
# wash_phase_timer

Programmable phase-duration timer and scheduler for the washing-machine controller. It takes the controller's `phase_sel`/`timer_enable` request, loads the configured duration for that phase (SOAK/WASH/RINSE/SPIN), and counts it down on a prescaled time base. It freezes on power loss and returns `timer_done` to the controller's next-state logic. Durations are runtime-configurable through a simple register write port.

## Interface
Parameters:
- `CNT_W`, 16: width of duration registers and `remaining`.
- `PRESCALE`, 1000: clk cycles per time unit; must be ≥ 1.
- `SOAK_DEF`, 10: reset duration for phase 2'b00, in time units.
- `WASH_DEF`, 20: reset duration for phase 2'b01.
- `RINSE_DEF`, 15: reset duration for phase 2'b10.
- `SPIN_DEF`, 8: reset duration for phase 2'b11.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `timer_enable`, in, 1: controller requests timing of the current phase.
- `phase_sel`, in, 2: phase being timed (00 soak, 01 wash, 10 rinse, 11 spin).
- `power_on`, in, 1: low freezes counting.
- `cancel`, in, 1: abort the current phase timing.
- `cfg_we`, in, 1: duration register write strobe.
- `cfg_addr`, in, 2: duration register index (same encoding as `phase_sel`).
- `cfg_data`, in, CNT_W: duration value, in time units.
- `timer_done`, out, 1: phase complete; held until consumed.
- `remaining`, out, CNT_W: time units left in the current phase.
- `running`, out, 1: high in COUNT or PAUSE.
- `paused`, out, 1: high in PAUSE.

## Operation
- Registers:
  - `dur[0:3]` hold the phase durations.
  - `cur_phase` holds the latched phase.
  - `pre` is the prescaler, `$clog2(PRESCALE)` bits wide (minimum 1).
  - State is one of IDLE, LOAD, COUNT, PAUSE, DONE, WAIT.
- Config writes:
  - `cfg_we` writes `dur[cfg_addr] <= cfg_data` in any state.
  - A new value takes effect only at the next LOAD.
  - A write in the same cycle as a LOAD of the same index is not seen by that LOAD; the old value is used.
- IDLE: if `timer_enable & power_on & !cancel`, go to LOAD.
- LOAD:
  - Set `cur_phase <= phase_sel`, `remaining <= dur[phase_sel]`, `pre <= 0`.
  - If `dur[phase_sel] == 0`, go to DONE; otherwise go to COUNT.
- COUNT. Priority order:
  1. `cancel` or `!timer_enable`: go to IDLE and clear `remaining`.
  2. `phase_sel != cur_phase`: go to LOAD.
  3. `!power_on`: go to PAUSE; `pre` and `remaining` hold.
  4. Otherwise, `pre` increments. When `pre == PRESCALE-1`, set `pre <= 0` and decrement `remaining`. If `remaining == 1` on that tick, go to DONE.
- PAUSE:
  - Same cancel/disable exit to IDLE.
  - `power_on` high returns to COUNT; counting resumes with no lost or extra cycles.
  - A phase change while paused takes effect after resuming.
- DONE:
  - `timer_done = 1`, `remaining = 0`.
  - Exits to WAIT only on a cycle with `power_on = 1`, so the controller's frozen state register always observes the done.
  - `cancel` exits to IDLE.
- WAIT:
  - `timer_done = 0`; the timer does not re-arm on the same phase.
  - `phase_sel != cur_phase` with `timer_enable` high: go to LOAD.
  - `!timer_enable` or `cancel`: go to IDLE.
- `remaining` never underflows. Arithmetic is unsigned, CNT_W bits.

## Timing
- Reset values:
  - State IDLE; `timer_done`, `running`, `paused` = 0; `remaining` = 0; `pre` = 0.
  - `dur` = {SOAK_DEF, WASH_DEF, RINSE_DEF, SPIN_DEF}.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- Latency, with `power_on` held high and D = loaded duration, P = PRESCALE:
  - Edge e0 samples `timer_enable` in IDLE; edge e1 performs LOAD.
  - `timer_done` rises after edge e(1 + D·P).
  - For D = 0, `timer_done` rises after e1.
- Each cycle with `power_on` low in COUNT/PAUSE adds exactly one cycle to the completion time.
- Phase change to reload: `phase_sel` changes at COUNT/WAIT, LOAD follows at the next edge, then COUNT or DONE one edge later.
- Reset mid-count forces IDLE and reloads the default `dur`, discarding any configured values.

## Test plan
Sim parameters: PRESCALE=4, defaults 3/2/2/1.
- Reset, then `timer_enable=1`, `phase_sel=00`. Required: `remaining` = 3, 2, 1, 0 at 4-cycle spacing; `timer_done` high exactly 13 edges after enable is sampled, then WAIT with `timer_done=0`.
- Full sequence: the controller steps `phase_sel` 00→01→10→11 after each `timer_done`. Required: done intervals of 12, 8, 8, 4 timed cycles plus 2 reload edges each; after the final done, `timer_enable=0` returns the block to IDLE.
- Power freeze: drop `power_on` for 5 cycles at `remaining=2` during WASH. Required: `paused=1`, `remaining` frozen at 2, `timer_done` delayed by exactly 5 cycles. Separately, hold `power_on=0` while in DONE: `timer_done` stays high until `power_on` returns.
- Cancel mid-RINSE at `remaining=1`. Required: IDLE next edge, `remaining=0`, `running=0`, no `timer_done`.
- Config: write `cfg_addr=00`, `cfg_data=5` during a WASH count. Required: the current WASH is unaffected; the next SOAK loads 5 (20 counting cycles). Write `dur[11]=0`, then enter SPIN: `timer_done` one edge after LOAD.
- Assert `rst_n=0` asynchronously mid-COUNT. Required: outputs reset immediately, without waiting for a clock edge; `dur` returns to defaults.
